// File: rtl/amm_sched_pkg.sv
// -----------------------------------------------------------------------------
// amm_sched_pkg
// Shared types and default widths for the Avalon-MM transfer scheduler.
//   state_t : scheduler FSM states (IDLE, ISSUE, WAIT, DONE)
//   xfer_t  : one transfer descriptor (direction, fixed flag, base, length)
//             sized for the default address width
// -----------------------------------------------------------------------------
package amm_sched_pkg;

  localparam int DEF_ADDRESSWIDTH = 28;
  localparam int DEF_DATAWIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                        write;
    logic                        fixed;
    logic [DEF_ADDRESSWIDTH-1:0] addr;
    logic [DEF_ADDRESSWIDTH-1:0] length;
  } xfer_t;

endpackage

// File: rtl/amm_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// amm_sched_rr_arb
// Two-input round-robin pick, purely combinational.
//   req_valid_i [1:0] : requests from requester 0 and 1
//   last_grant_i      : index of the requester served most recently
//   any_o             : at least one request is pending
//   g_o               : index of the requester to serve next
// -----------------------------------------------------------------------------
module amm_sched_rr_arb (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       any_o,
  output logic       g_o
);

  // A lone request wins outright; on a tie the requester that was not served
  // last goes next, which is what makes the pick fair under contention.
  always_comb begin
    any_o = |req_valid_i;
    if (&req_valid_i) begin
      g_o = ~last_grant_i;
    end else begin
      g_o = req_valid_i[1];
    end
  end

endmodule

// File: rtl/amm_xfer_scheduler.sv
// -----------------------------------------------------------------------------
// amm_xfer_scheduler
// Shares one Avalon-MM burst master between requester 0 (PCIe host command
// path) and requester 1 (face-recognition engine). One transfer at a time is
// sequenced through the master's go/done handshake; a watchdog aborts
// transfers whose done never arrives.
//   clk, reset                     : clock, synchronous active-high reset
//   req_valid/write/fixed/addr/length [1:0] : per-requester transfer request
//   req_ready/done/err [1:0]       : one-cycle accepted / finished / abnormal
//   grant, busy                    : current/last granted index, not-idle flag
//   req_wr_* / req_rd_*            : per-requester user buffer ports
//   ctl_wr_* / ctl_rd_*            : master control ports
//   usr_wr_* / usr_rd_*            : master user buffer ports
// -----------------------------------------------------------------------------
module amm_xfer_scheduler
  import amm_sched_pkg::*;
#(
  parameter int ADDRESSWIDTH   = DEF_ADDRESSWIDTH,
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_valid,
  input  logic [1:0]                   req_write,
  input  logic [1:0]                   req_fixed,
  input  logic [1:0][ADDRESSWIDTH-1:0] req_addr,
  input  logic [1:0][ADDRESSWIDTH-1:0] req_length,
  output logic [1:0]                   req_ready,
  output logic [1:0]                   req_done,
  output logic [1:0]                   req_err,
  output logic                         grant,
  output logic                         busy,
  input  logic [1:0]                   req_wr_buffer,
  input  logic [1:0][DATAWIDTH-1:0]    req_wr_data,
  output logic [1:0]                   req_wr_full,
  input  logic [1:0]                   req_rd_buffer,
  output logic [DATAWIDTH-1:0]         req_rd_data,
  output logic [1:0]                   req_rd_nonempty,
  output logic                         ctl_wr_go,
  output logic                         ctl_wr_fixed_location,
  output logic [ADDRESSWIDTH-1:0]      ctl_wr_addr_base,
  output logic [ADDRESSWIDTH-1:0]      ctl_wr_length,
  input  logic                         ctl_wr_done,
  output logic                         ctl_rd_go,
  output logic                         ctl_rd_fixed_location,
  output logic [ADDRESSWIDTH-1:0]      ctl_rd_addr_base,
  output logic [ADDRESSWIDTH-1:0]      ctl_rd_length,
  input  logic                         ctl_rd_done,
  output logic                         usr_wr_buffer,
  output logic [DATAWIDTH-1:0]         usr_wr_buffer_data,
  input  logic                         usr_wr_buffer_full,
  output logic                         usr_rd_buffer,
  input  logic [DATAWIDTH-1:0]         usr_rd_buffer_data,
  input  logic                         usr_rd_buffer_nonempty
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Descriptor sized for this instance's address width.
  typedef struct packed {
    logic                    write;
    logic                    fixed;
    logic [ADDRESSWIDTH-1:0] addr;
    logic [ADDRESSWIDTH-1:0] length;
  } xfer_rec_t;

  state_t          state_q;
  xfer_rec_t       xfer_q;
  xfer_rec_t       xfer_d;
  logic            grant_q;
  logic            last_grant_q;
  logic            busy_q;
  logic [1:0]      ready_q;
  logic [1:0]      done_q;
  logic [1:0]      err_q;
  logic            wr_go_q;
  logic            rd_go_q;
  logic [WD_W-1:0] wdog_q;

  logic            arb_any;
  logic            arb_g;
  logic            dir_done;
  logic            route_active;

  amm_sched_rr_arb u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (arb_any),
    .g_o          (arb_g)
  );

  // Descriptor of whichever requester the arbiter is currently picking.
  always_comb begin
    xfer_d.write  = req_write[arb_g];
    xfer_d.fixed  = req_fixed[arb_g];
    xfer_d.addr   = req_addr[arb_g];
    xfer_d.length = req_length[arb_g];
  end

  // Only the done of the direction actually issued can end a transfer.
  assign dir_done = xfer_q.write ? ctl_wr_done : ctl_rd_done;

  // Scheduler FSM. All pulses are registered and set on the transition into
  // the state where they must be visible, so they are glitch-free. A zero
  // length request skips the master entirely and reports ready, done and
  // err together in its single DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      xfer_q       <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      ready_q      <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      wr_go_q      <= 1'b0;
      rd_go_q      <= 1'b0;
      wdog_q       <= '0;
    end else begin
      ready_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      wr_go_q <= 1'b0;
      rd_go_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q        <= arb_g;
            xfer_q         <= xfer_d;
            busy_q         <= 1'b1;
            ready_q[arb_g] <= 1'b1;
            if (xfer_d.length == '0) begin
              state_q       <= DONE;
              done_q[arb_g] <= 1'b1;
              err_q[arb_g]  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              wr_go_q <= xfer_d.write;
              rd_go_q <= ~xfer_d.write;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wdog_q  <= '0;
        end
        WAIT: begin
          // A done in the expiry cycle takes priority over the abort.
          if (dir_done) begin
            state_q         <= DONE;
            done_q[grant_q] <= 1'b1;
          end else if (wdog_q == WD_LAST) begin
            state_q         <= DONE;
            done_q[grant_q] <= 1'b1;
            err_q[grant_q]  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        DONE: begin
          state_q      <= IDLE;
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

  // Both directions carry the latched descriptor; only one go ever fires.
  assign ctl_wr_go             = wr_go_q;
  assign ctl_wr_fixed_location = xfer_q.fixed;
  assign ctl_wr_addr_base      = xfer_q.addr;
  assign ctl_wr_length         = xfer_q.length;
  assign ctl_rd_go             = rd_go_q;
  assign ctl_rd_fixed_location = xfer_q.fixed;
  assign ctl_rd_addr_base      = xfer_q.addr;
  assign ctl_rd_length         = xfer_q.length;

  assign route_active = (state_q == ISSUE) || (state_q == WAIT);

  // User buffer routing. Outside an active transfer, and for the requester
  // not granted, the write side looks full and the read side empty so nobody
  // can push or pop data that is not theirs.
  always_comb begin
    usr_wr_buffer      = 1'b0;
    usr_wr_buffer_data = '0;
    usr_rd_buffer      = 1'b0;
    req_wr_full        = 2'b11;
    req_rd_nonempty    = 2'b00;
    if (route_active) begin
      if (xfer_q.write) begin
        usr_wr_buffer        = req_wr_buffer[grant_q];
        usr_wr_buffer_data   = req_wr_data[grant_q];
        req_wr_full[grant_q] = usr_wr_buffer_full;
      end else begin
        usr_rd_buffer            = req_rd_buffer[grant_q];
        req_rd_nonempty[grant_q] = usr_rd_buffer_nonempty;
      end
    end
  end

  assign req_rd_data = usr_rd_buffer_data;

endmodule

// File: tb/tb_amm_xfer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_amm_xfer_scheduler
// Self-checking bench for amm_xfer_scheduler with a 16-cycle watchdog.
// Each test task drives one scenario and checks inline; completions are
// pushed to a scoreboard queue when a request is driven and popped by a
// negedge monitor whenever req_done pulses.
// -----------------------------------------------------------------------------
module tb_amm_xfer_scheduler;
  import amm_sched_pkg::*;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    int idx;
    bit err;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_write = '0;
  logic [1:0]          req_fixed = '0;
  logic [1:0][AW-1:0]  req_addr = '0;
  logic [1:0][AW-1:0]  req_length = '0;
  logic [1:0]          req_ready;
  logic [1:0]          req_done;
  logic [1:0]          req_err;
  logic                grant;
  logic                busy;
  logic [1:0]          req_wr_buffer = '0;
  logic [1:0][DW-1:0]  req_wr_data = '0;
  logic [1:0]          req_wr_full;
  logic [1:0]          req_rd_buffer = '0;
  logic [DW-1:0]       req_rd_data;
  logic [1:0]          req_rd_nonempty;
  logic                ctl_wr_go;
  logic                ctl_wr_fixed_location;
  logic [AW-1:0]       ctl_wr_addr_base;
  logic [AW-1:0]       ctl_wr_length;
  logic                ctl_wr_done = 1'b0;
  logic                ctl_rd_go;
  logic                ctl_rd_fixed_location;
  logic [AW-1:0]       ctl_rd_addr_base;
  logic [AW-1:0]       ctl_rd_length;
  logic                ctl_rd_done = 1'b0;
  logic                usr_wr_buffer;
  logic [DW-1:0]       usr_wr_buffer_data;
  logic                usr_wr_buffer_full = 1'b0;
  logic                usr_rd_buffer;
  logic [DW-1:0]       usr_rd_buffer_data = '0;
  logic                usr_rd_buffer_nonempty = 1'b0;

  exp_t sb[$];
  exp_t monExp;
  logic [1:0] monWantDone;
  logic [1:0] monWantErr;
  int nChecks = 0;
  int nFails  = 0;

  amm_xfer_scheduler #(
    .ADDRESSWIDTH   (AW),
    .DATAWIDTH      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_write              (req_write),
    .req_fixed              (req_fixed),
    .req_addr               (req_addr),
    .req_length             (req_length),
    .req_ready              (req_ready),
    .req_done               (req_done),
    .req_err                (req_err),
    .grant                  (grant),
    .busy                   (busy),
    .req_wr_buffer          (req_wr_buffer),
    .req_wr_data            (req_wr_data),
    .req_wr_full            (req_wr_full),
    .req_rd_buffer          (req_rd_buffer),
    .req_rd_data            (req_rd_data),
    .req_rd_nonempty        (req_rd_nonempty),
    .ctl_wr_go              (ctl_wr_go),
    .ctl_wr_fixed_location  (ctl_wr_fixed_location),
    .ctl_wr_addr_base       (ctl_wr_addr_base),
    .ctl_wr_length          (ctl_wr_length),
    .ctl_wr_done            (ctl_wr_done),
    .ctl_rd_go              (ctl_rd_go),
    .ctl_rd_fixed_location  (ctl_rd_fixed_location),
    .ctl_rd_addr_base       (ctl_rd_addr_base),
    .ctl_rd_length          (ctl_rd_length),
    .ctl_rd_done            (ctl_rd_done),
    .usr_wr_buffer          (usr_wr_buffer),
    .usr_wr_buffer_data     (usr_wr_buffer_data),
    .usr_wr_buffer_full     (usr_wr_buffer_full),
    .usr_rd_buffer          (usr_rd_buffer),
    .usr_rd_buffer_data     (usr_rd_buffer_data),
    .usr_rd_buffer_nonempty (usr_rd_buffer_nonempty)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Scoreboard monitor: every req_done pulse must match the oldest pending
  // expectation in both requester index and error flag.
  always @(negedge clk) begin
    if (req_done !== 2'b00) begin
      nChecks++;
      if (sb.size() == 0) begin
        nFails++;
        $display("[TB] FAIL sb_unexpected_done: got req_done=%b, want no pending completion", req_done);
      end else begin
        monExp      = sb.pop_front();
        monWantDone = (monExp.idx == 1) ? 2'b10 : 2'b01;
        monWantErr  = monExp.err ? monWantDone : 2'b00;
        if (req_done !== monWantDone) begin
          nFails++;
          $display("[TB] FAIL sb_done_idx: got %b want %b", req_done, monWantDone);
        end
        nChecks++;
        if (req_err !== monWantErr) begin
          nFails++;
          $display("[TB] FAIL sb_err: got %b want %b", req_err, monWantErr);
        end
      end
    end
  end

  // Hard stop in case the DUT or the bench wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] aborting");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input xfer_t x);
    req_write[idx]  = x.write;
    req_fixed[idx]  = x.fixed;
    req_addr[idx]   = x.addr;
    req_length[idx] = x.length;
    req_valid[idx]  = 1'b1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    nChecks++;
    if ({busy, grant} !== 2'b00) begin
      nFails++; $display("[TB] FAIL reset_busy_grant: got %b want 00", {busy, grant});
    end
    nChecks++;
    if ({req_ready, req_done, req_err, ctl_wr_go, ctl_rd_go} !== 8'h00) begin
      nFails++; $display("[TB] FAIL reset_pulses: got %b want 0", {req_ready, req_done, req_err, ctl_wr_go, ctl_rd_go});
    end
    nChecks++;
    if ({ctl_wr_addr_base, ctl_wr_length, ctl_rd_addr_base, ctl_rd_length} !== '0) begin
      nFails++; $display("[TB] FAIL reset_ctl_fields: got %h want 0", {ctl_wr_addr_base, ctl_wr_length});
    end
    nChecks++;
    if ({req_wr_full, req_rd_nonempty, usr_wr_buffer, usr_rd_buffer} !== 6'b110000) begin
      nFails++; $display("[TB] FAIL reset_routing: got %b want 110000", {req_wr_full, req_rd_nonempty, usr_wr_buffer, usr_rd_buffer});
    end
  endtask

  task automatic test_single_write();
    xfer_t x;
    x = '{write: 1'b1, fixed: 1'b0, addr: 28'h100, length: 28'd64};
    sb.push_back('{idx: 0, err: 1'b0});
    applyStimulus(0, x);
    tick();
    nChecks++;
    if ({req_ready, ctl_wr_go, ctl_rd_go, busy, grant} !== 6'b011010) begin
      nFails++; $display("[TB] FAIL wr_issue: got %b want 011010", {req_ready, ctl_wr_go, ctl_rd_go, busy, grant});
    end
    nChecks++;
    if (ctl_wr_addr_base !== 28'h100 || ctl_wr_length !== 28'd64) begin
      nFails++; $display("[TB] FAIL wr_fields: got %h/%0d want 100/64", ctl_wr_addr_base, ctl_wr_length);
    end
    req_valid[0] = 1'b0;
    tick();
    nChecks++;
    if ({ctl_wr_go, req_ready} !== 3'b000 || ctl_wr_addr_base !== 28'h100) begin
      nFails++; $display("[TB] FAIL wr_wait: got go=%b ready=%b addr=%h want 0/00/100", ctl_wr_go, req_ready, ctl_wr_addr_base);
    end
    req_wr_buffer = 2'b01;
    req_wr_data[0] = 32'hA5A5_0001;
    req_wr_data[1] = 32'h1111_2222;
    usr_wr_buffer_full = 1'b0;
    usr_rd_buffer_nonempty = 1'b1;
    #1;
    nChecks++;
    if ({usr_wr_buffer, req_wr_full, req_rd_nonempty} !== 5'b11000 || usr_wr_buffer_data !== 32'hA5A5_0001) begin
      nFails++; $display("[TB] FAIL wr_routing: got %b data=%h want 11000 data=a5a50001", {usr_wr_buffer, req_wr_full, req_rd_nonempty}, usr_wr_buffer_data);
    end
    req_wr_buffer = 2'b00;
    usr_rd_buffer_nonempty = 1'b0;
    ctl_wr_done = 1'b1;
    tick();
    ctl_wr_done = 1'b0;
    nChecks++;
    if (req_done !== 2'b01) begin
      nFails++; $display("[TB] FAIL wr_done_latency: got %b want 01", req_done);
    end
    tick();
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL wr_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_contention();
    int served = 0;
    int issued = 0;
    int cyc = 0;
    bit doneNext = 1'b0;
    logic [1:0] wantGrant [4];
    wantGrant[0] = 2'd0; wantGrant[1] = 2'd1; wantGrant[2] = 2'd0; wantGrant[3] = 2'd1;
    pulseReset();
    for (int i = 0; i < 4; i++) sb.push_back('{idx: i % 2, err: 1'b0});
    applyStimulus(0, '{write: 1'b0, fixed: 1'b0, addr: 28'h40, length: 28'd8});
    applyStimulus(1, '{write: 1'b0, fixed: 1'b0, addr: 28'h80, length: 28'd8});
    while (served < 4 && cyc < 200) begin
      tick();
      cyc++;
      ctl_rd_done = 1'b0;
      if (doneNext) begin
        ctl_rd_done = 1'b1;
        doneNext = 1'b0;
      end
      if (ctl_rd_go === 1'b1) begin
        doneNext = 1'b1;
        nChecks++;
        if (issued < 4 && ({1'b0, grant} !== wantGrant[issued] || ctl_rd_addr_base !== (grant ? 28'h80 : 28'h40))) begin
          nFails++; $display("[TB] FAIL rr_grant_%0d: got grant=%b addr=%h want %0d", issued, grant, ctl_rd_addr_base, wantGrant[issued]);
        end
        issued++;
      end
      if (req_done !== 2'b00) served++;
      if (served == 4) req_valid = 2'b00;
    end
    ctl_rd_done = 1'b0;
    req_valid = 2'b00;
    nChecks++;
    if (served != 4) begin
      nFails++; $display("[TB] FAIL rr_budget: got %0d completions want 4", served);
    end
    tick();
  endtask

  task automatic test_read_isolation();
    xfer_t x;
    x = '{write: 1'b0, fixed: 1'b0, addr: 28'h200, length: 28'd16};
    sb.push_back('{idx: 1, err: 1'b0});
    applyStimulus(1, x);
    tick();
    nChecks++;
    if ({req_ready, ctl_rd_go, ctl_wr_go, grant} !== 5'b10101 || ctl_wr_addr_base !== 28'h200 || ctl_rd_addr_base !== 28'h200) begin
      nFails++; $display("[TB] FAIL rd_issue: got %b wr=%h rd=%h want 10101 200 200", {req_ready, ctl_rd_go, ctl_wr_go, grant}, ctl_wr_addr_base, ctl_rd_addr_base);
    end
    req_valid[1] = 1'b0;
    tick();
    usr_rd_buffer_nonempty = 1'b1;
    usr_wr_buffer_full = 1'b0;
    usr_rd_buffer_data = 32'hDEAD_BEEF;
    req_rd_buffer = 2'b01;
    #1;
    nChecks++;
    if ({req_rd_nonempty, req_wr_full, usr_rd_buffer, usr_wr_buffer} !== 6'b101100 || req_rd_data !== 32'hDEAD_BEEF) begin
      nFails++; $display("[TB] FAIL rd_isolation: got %b data=%h want 101100 deadbeef", {req_rd_nonempty, req_wr_full, usr_rd_buffer, usr_wr_buffer}, req_rd_data);
    end
    req_rd_buffer = 2'b10;
    #1;
    nChecks++;
    if (usr_rd_buffer !== 1'b1) begin
      nFails++; $display("[TB] FAIL rd_buffer_route: got %b want 1", usr_rd_buffer);
    end
    usr_rd_buffer_nonempty = 1'b0;
    req_rd_buffer = 2'b00;
    #1;
    nChecks++;
    if (req_rd_nonempty !== 2'b00) begin
      nFails++; $display("[TB] FAIL rd_nonempty_follow: got %b want 00", req_rd_nonempty);
    end
    ctl_wr_done = 1'b1;
    tick();
    ctl_wr_done = 1'b0;
    nChecks++;
    if (busy !== 1'b1 || req_done !== 2'b00) begin
      nFails++; $display("[TB] FAIL rd_wrong_dir_done: got busy=%b done=%b want 1 00", busy, req_done);
    end
    ctl_rd_done = 1'b1;
    tick();
    ctl_rd_done = 1'b0;
    nChecks++;
    if (req_done !== 2'b10) begin
      nFails++; $display("[TB] FAIL rd_done: got %b want 10", req_done);
    end
    tick();
  endtask

  task automatic test_zero_length();
    sb.push_back('{idx: 1, err: 1'b1});
    applyStimulus(1, '{write: 1'b1, fixed: 1'b0, addr: 28'h300, length: 28'd0});
    tick();
    nChecks++;
    if ({req_ready, req_done, req_err, ctl_wr_go, ctl_rd_go, busy} !== 9'b101010001) begin
      nFails++; $display("[TB] FAIL zero_len_pulse: got %b want 101010001", {req_ready, req_done, req_err, ctl_wr_go, ctl_rd_go, busy});
    end
    req_valid[1] = 1'b0;
    tick();
    nChecks++;
    if ({busy, ctl_wr_go, ctl_rd_go, req_ready} !== 5'b00000) begin
      nFails++; $display("[TB] FAIL zero_len_after: got %b want 00000", {busy, ctl_wr_go, ctl_rd_go, req_ready});
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit early = 1'b0;
    sb.push_back('{idx: 0, err: 1'b1});
    applyStimulus(0, '{write: 1'b1, fixed: 1'b0, addr: 28'h400, length: 28'd32});
    tick();
    req_valid[0] = 1'b0;
    tick();
    while (cnt < 40) begin
      tick();
      cnt++;
      if (req_done !== 2'b00) break;
    end
    nChecks++;
    if (cnt != TO || req_err !== 2'b01) begin
      nFails++; $display("[TB] FAIL timeout_expiry: got %0d cycles err=%b want %0d 01", cnt, req_err, TO);
    end
    tick();
    ctl_wr_done = 1'b1;
    ctl_rd_done = 1'b1;
    tick();
    ctl_wr_done = 1'b0;
    ctl_rd_done = 1'b0;
    nChecks++;
    if ({busy, req_done, req_ready} !== 5'b00000) begin
      nFails++; $display("[TB] FAIL late_done: got %b want 00000", {busy, req_done, req_ready});
    end
    sb.push_back('{idx: 1, err: 1'b0});
    applyStimulus(1, '{write: 1'b0, fixed: 1'b1, addr: 28'h500, length: 28'd8});
    tick();
    req_valid[1] = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (req_done !== 2'b00) early = 1'b1;
    end
    nChecks++;
    if (early !== 1'b0 || ctl_rd_fixed_location !== 1'b1) begin
      nFails++; $display("[TB] FAIL expiry_pre: got early=%b fixed=%b want 0 1", early, ctl_rd_fixed_location);
    end
    ctl_rd_done = 1'b1;
    tick();
    ctl_rd_done = 1'b0;
    nChecks++;
    if (req_done !== 2'b10 || req_err !== 2'b00) begin
      nFails++; $display("[TB] FAIL expiry_done_wins: got done=%b err=%b want 10 00", req_done, req_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    sb.push_back('{idx: 0, err: 1'b1});
    applyStimulus(0, '{write: 1'b0, fixed: 1'b0, addr: 28'h600, length: 28'd0});
    tick();
    req_valid[0] = 1'b0;
    tick();
    applyStimulus(1, '{write: 1'b0, fixed: 1'b0, addr: 28'h700, length: 28'd4});
    tick();
    req_valid[1] = 1'b0;
    tick();
    nChecks++;
    if (busy !== 1'b1) begin
      nFails++; $display("[TB] FAIL mid_wait_busy: got %b want 1", busy);
    end
    pulseReset();
    nChecks++;
    if ({busy, req_done, ctl_rd_go} !== 4'b0000) begin
      nFails++; $display("[TB] FAIL mid_wait_reset: got %b want 0000", {busy, req_done, ctl_rd_go});
    end
    ctl_rd_done = 1'b1;
    tick();
    ctl_rd_done = 1'b0;
    nChecks++;
    if (req_done !== 2'b00) begin
      nFails++; $display("[TB] FAIL mid_wait_no_done: got %b want 00", req_done);
    end
    applyStimulus(0, '{write: 1'b0, fixed: 1'b0, addr: 28'h800, length: 28'd4});
    applyStimulus(1, '{write: 1'b0, fixed: 1'b0, addr: 28'h900, length: 28'd4});
    tick();
    nChecks++;
    if (req_ready !== 2'b01 || grant !== 1'b0) begin
      nFails++; $display("[TB] FAIL post_reset_grant: got ready=%b grant=%b want 01 0", req_ready, grant);
    end
    req_valid = 2'b00;
    pulseReset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_read_isolation();
    test_zero_length();
    test_timeout();
    test_reset_mid_wait();
    tick();
    nChecks++;
    if (sb.size() != 0) begin
      nFails++; $display("[TB] FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/amm_xfer_scheduler.md
# amm_xfer_scheduler

- Shares the single Avalon-MM burst master (the SDRAM read/write master inside the Qsys system) between two requesters: requester 0 is the PCIe host command path; requester 1 is the face-recognition compute engine.
- Round-robin arbitration; sequences one transfer at a time through the master's go/done control handshake.
- Routes the master's user write and read buffers to the granted requester only.
- Watchdog aborts transfers that never complete.

## Interface

- ADDRESSWIDTH, 28, width of address base and length.
- DATAWIDTH, 32, user buffer data width.
- TIMEOUT_CYCLES, 1048576, WAIT-state cycles before abort (≥2).
- clk  in  1  system clock (50 MHz).
- reset  in  1  **one clock; reset is synchronous and active-high.**
- req_valid  in  [1:0]  transfer request; held with its fields until req_ready.
- req_write  in  [1:0]  1 = write to SDRAM, 0 = read.
- req_fixed  in  [1:0]  fixed-location transfer.
- req_addr / req_length  in  [1:0][ADDRESSWIDTH-1:0]  byte base address / byte count.
- req_ready / req_done / req_err  out  [1:0]  one-cycle pulses: accepted / finished / finished abnormally.
- grant  out  1  index of the current/last granted requester.
- busy  out  1  high in every state other than IDLE.
- req_wr_buffer  in  [1:0]; req_wr_data  in  [1:0][DATAWIDTH-1:0]; req_wr_full  out  [1:0].
- req_rd_buffer  in  [1:0]; req_rd_data  out  DATAWIDTH; req_rd_nonempty  out  [1:0].
- ctl_wr_go, ctl_wr_fixed_location, ctl_wr_addr_base, ctl_wr_length  out; ctl_wr_done  in.
- ctl_rd_go, ctl_rd_fixed_location, ctl_rd_addr_base, ctl_rd_length  out; ctl_rd_done  in.
- usr_wr_buffer, usr_wr_buffer_data  out; usr_wr_buffer_full  in.
- usr_rd_buffer  out; usr_rd_buffer_data, usr_rd_buffer_nonempty  in.

## Operation

**FSM states:** IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - If any req_valid is set, choose g:
    - Only one valid: that requester.
    - Both valid: the requester other than last_grant.
  - Latch g's write, fixed, addr and length.
  - Go to ISSUE, or to DONE if length == 0.
- **ISSUE** (one cycle)
  - req_ready[g] = 1.
  - ctl_wr_go = 1 for a write, ctl_rd_go = 1 for a read.
  - Go to WAIT.
- **WAIT**
  - Exit on the done of the latched direction → DONE, err = 0.
  - The other direction's done is ignored.
  - Watchdog counts WAIT cycles; reaching TIMEOUT_CYCLES-1 with no done → DONE, err = 1.
  - Done in the expiry cycle wins: err = 0.
- **DONE** (one cycle)
  - req_done[g] = 1; req_err[g] = latched err.
  - last_grant ← g; go to IDLE.
- **Zero length**
  - DONE is entered directly from IDLE with err = 1.
  - req_ready[g], req_done[g] and req_err[g] all pulse in that one DONE cycle.
  - No go is issued.
- **Control outputs**
  - ctl_*_addr_base, ctl_*_length and ctl_*_fixed_location are driven from the latched values and stay stable from ISSUE through the WAIT exit.
  - Both directions' fields carry the latched values; only one go fires.
- **Data routing** (combinational; active in ISSUE/WAIT only, for the latched direction)
  - Write: usr_wr_buffer = req_wr_buffer[g]; usr_wr_buffer_data = req_wr_data[g]; req_wr_full[g] = usr_wr_buffer_full.
  - Read: usr_rd_buffer = req_rd_buffer[g]; req_rd_nonempty[g] = usr_rd_buffer_nonempty.
  - Non-granted or idle: req_wr_full = 1, req_rd_nonempty = 0, usr_wr_buffer = 0, usr_rd_buffer = 0.
  - req_rd_data = usr_rd_buffer_data, always broadcast.
- **Late done:** a done arriving in IDLE (after a timeout) is ignored.

## Timing

- **Reset values**
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - grant = 0; busy = 0.
  - All go/ready/done/err = 0; ctl fields = 0; watchdog = 0.
- **Reset mid-transfer:** returns to IDLE next cycle with no done pulse; the requester must re-request.
- **Latency**
  - req_valid seen in IDLE at cycle N → ISSUE at N+1 (req_ready and go in the same cycle).
  - ctl_*_done at cycle M → req_done at M+1 → IDLE at M+2 → next ISSUE no earlier than M+3.
- **Request rules:** requesters must not drop req_valid or change fields before req_ready; req_valid seen in the DONE cycle is arbitrated in the following IDLE.
- **Watchdog:** counter width is $clog2(TIMEOUT_CYCLES); cleared on WAIT entry; never wraps.

## Structure

- **Package amm_sched_pkg**
  - state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - xfer_t struct {write, fixed, addr, length}.
  - Default ADDRESSWIDTH/DATAWIDTH constants.
- **Sub-module amm_sched_rr_arb**
  - Two-input round-robin pick.
  - Inputs: req_valid, last_grant. Outputs: any, g.
  - Combinational, separately testable.
- **Top level:** FSM, latches, watchdog and data mux live in amm_xfer_scheduler.

## Test plan

- **Single write:** req_valid[0], write, addr 0x100, length 64 → ISSUE the next cycle with ctl_wr_go = 1 (one cycle), ctl_wr_addr_base 0x100, ctl_wr_length 64; ctl_wr_done → req_done[0] one cycle later, req_err = 0.
- **Contention:** both requesters hold valid continuously → grants alternate 0,1,0,1; no requester is served twice in a row.
- **Data isolation during read for req 1:** req_rd_nonempty[1] follows usr_rd_buffer_nonempty, req_rd_nonempty[0] = 0, req_wr_full = 2'b11; req_rd_buffer[0] pulses never reach usr_rd_buffer.
- **Zero length:** req 1, length 0 → single cycle with req_ready, req_done and req_err all 1; no go.
- **Timeout:** TIMEOUT_CYCLES = 16, withhold done → req_done and req_err at WAIT entry + 16; a late done in IDLE is ignored. Done in the expiry cycle → err = 0.
- **Reset mid-WAIT** → IDLE, busy = 0, no req_done; the next request is granted to requester 0.
